// File: rtl/tile_sequencer_if.sv
// Handshake bundle between the host/datapath side and tile_sequencer.
// The sequencer connects through the slave modport; the environment uses master.
interface tile_sequencer_if #(
    parameter int TILE_CNT_W = 8
);
    logic                  start;
    logic [TILE_CNT_W-1:0] num_tiles;
    logic                  busy;
    logic                  done;
    logic                  load_weight_en;
    logic                  load_weight_done;
    logic                  load_data_exec_en;
    logic                  load_data_exec_done;
    logic                  adder_en;
    logic                  adder_done;
    logic                  write_output_en;
    logic                  write_output_done;
    logic                  is_last;
    logic [TILE_CNT_W-1:0] tile_idx;
    logic                  err_timeout;

    modport slave (
        input  start,
        input  num_tiles,
        input  load_weight_done,
        input  load_data_exec_done,
        input  adder_done,
        input  write_output_done,
        output busy,
        output done,
        output load_weight_en,
        output load_data_exec_en,
        output adder_en,
        output write_output_en,
        output is_last,
        output tile_idx,
        output err_timeout
    );

    modport master (
        output start,
        output num_tiles,
        output load_weight_done,
        output load_data_exec_done,
        output adder_done,
        output write_output_done,
        input  busy,
        input  done,
        input  load_weight_en,
        input  load_data_exec_en,
        input  adder_en,
        input  write_output_en,
        input  is_last,
        input  tile_idx,
        input  err_timeout
    );
endinterface

// File: rtl/tile_sequencer.sv
// Job scheduler: one weight load, then num_tiles x (data-exec, adder, write).
// Optional per-phase watchdog with sticky error enabled by SEQ_TIMEOUT_EN.
module tile_sequencer #(
    parameter int TILE_CNT_W  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic             clk,
    input logic             rst,
    tile_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        LW_REQ,
        LW_WAIT,
        LD_REQ,
        LD_WAIT,
        ADD,
        WR_REQ,
        WR_WAIT,
        NEXT,
        DONE
`ifdef SEQ_TIMEOUT_EN
        ,
        ERR
`endif
    } state_t;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    state_t                state_q;
    state_t                state_d;
    state_t                state_nx;
    logic [TILE_CNT_W-1:0] tile_idx_q;
    logic [TILE_CNT_W-1:0] tile_idx_d;
    logic [TILE_CNT_W-1:0] count_q;
    logic [TILE_CNT_W-1:0] count_d;
    logic                  busy;
    logic                  last;
    logic                  idle_like;

    // ERR accepts a new job exactly like IDLE does
`ifdef SEQ_TIMEOUT_EN
    assign idle_like = (state_q == IDLE) || (state_q == ERR);
`else
    assign idle_like = (state_q == IDLE);
`endif

    assign busy = state_q inside {LW_REQ, LW_WAIT, LD_REQ, LD_WAIT,
                                  ADD, WR_REQ, WR_WAIT, NEXT};

    // count_q is never 0 while busy, so count_q-1 cannot underflow here
    assign last = busy && (tile_idx_q == count_q - TILE_CNT_W'(1));

    // Phase sequencing, tile index and latched count
    always_comb begin
        state_nx   = state_q;
        tile_idx_d = tile_idx_q;
        count_d    = count_q;
        if (idle_like) begin
            if (bus.start) begin
                tile_idx_d = '0;
                if (bus.num_tiles != '0) begin
                    count_d  = bus.num_tiles;
                    state_nx = LW_REQ;
                end else begin
                    state_nx = DONE;
                end
            end
        end else begin
            case (state_q)
                LW_REQ: begin
                    state_nx = bus.load_weight_done ? LD_REQ : LW_WAIT;
                end
                LW_WAIT: begin
                    if (bus.load_weight_done) begin
                        state_nx = LD_REQ;
                    end
                end
                LD_REQ: begin
                    state_nx = bus.load_data_exec_done ? ADD : LD_WAIT;
                end
                LD_WAIT: begin
                    if (bus.load_data_exec_done) begin
                        state_nx = ADD;
                    end
                end
                ADD: begin
                    if (bus.adder_done) begin
                        state_nx = WR_REQ;
                    end
                end
                WR_REQ: begin
                    state_nx = bus.write_output_done ? NEXT : WR_WAIT;
                end
                WR_WAIT: begin
                    if (bus.write_output_done) begin
                        state_nx = NEXT;
                    end
                end
                NEXT: begin
                    if (last) begin
                        tile_idx_d = '0;
                        state_nx   = DONE;
                    end else begin
                        tile_idx_d = tile_idx_q + TILE_CNT_W'(1);
                        state_nx   = LD_REQ;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              waiting;

    assign waiting = state_q inside {LW_WAIT, LD_WAIT, ADD, WR_WAIT};

    // Watchdog: counts cycles spent in one wait phase, overrides to ERR
    always_comb begin
        state_d = state_nx;
        wdog_d  = '0;
        if (waiting && (state_nx == state_q)) begin
            if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
                state_d = ERR;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign bus.err_timeout = (state_q == ERR);
`else
    assign state_d         = state_nx;
    assign bus.err_timeout = 1'b0;
`endif

    // State, tile index and latched tile count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tile_idx_q <= tile_idx_d;
            count_q    <= count_d;
        end
    end

    assign bus.busy              = busy;
    assign bus.done              = (state_q == DONE);
    assign bus.load_weight_en    = (state_q == LW_REQ);
    assign bus.load_data_exec_en = (state_q == LD_REQ);
    assign bus.adder_en          = (state_q == ADD);
    assign bus.write_output_en   = (state_q == WR_REQ);
    assign bus.is_last           = last;
    assign bus.tile_idx          = tile_idx_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: per-job cycle traces built from phase durations.
// Exercise the watchdog by compiling with +define+SEQ_TIMEOUT_EN.
module tb_tile_sequencer;
    localparam int W  = 8;
    localparam int TO = 16;

    typedef struct {
        logic         st;
        logic [W-1:0] nt;
        logic         lwd;
        logic         ldd;
        logic         add;
        logic         wrd;
        logic [W+7:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_sequencer_if #(.TILE_CNT_W(W)) bus ();

    tile_sequencer #(
        .TILE_CNT_W (W),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    cyc_t trace[$];
    int   stray_pct = 25;
    int   st_pct = 10;
    logic model_err = 1'b0;
    int   model_idx = 0;
    int   mark_add1 = -1;
    int   mark_ldw = -1;
    int   o_lw, o_ld, o_add, o_wr, o_done, o_busy, o_err;
    int   o_done_at, o_last_min, o_last_max;

    function automatic logic [W+7:0] ev(input logic b, input logic d,
                                        input logic lw, input logic ld,
                                        input logic ad, input logic wr,
                                        input logic la, input logic er,
                                        input int idx);
        return {b, d, lw, ld, ad, wr, la, er, W'(idx)};
    endfunction

    function automatic logic [W+7:0] act();
        return {bus.busy, bus.done, bus.load_weight_en,
                bus.load_data_exec_en, bus.adder_en,
                bus.write_output_en, bus.is_last,
                bus.err_timeout, bus.tile_idx};
    endfunction

    task automatic cmp(input string nm, input int k,
                       input logic [W+7:0] a, input logic [W+7:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, k, a, e);
        end
    endtask

    task automatic pin(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
        end
    endtask

    // own: which done input belongs to this phase (-1 none)
    // st_mode: 0 start low, 1 start with nt, 2 random stray start
    task automatic add_cyc(input logic [W+7:0] e, input int own,
                           input logic own_v, input int st_mode,
                           input int nt);
        cyc_t c;
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i] = (i == own) ? own_v
                 : ($urandom_range(0, 99) < stray_pct);
        end
        c.lwd = d[0];
        c.ldd = d[1];
        c.add = d[2];
        c.wrd = d[3];
        c.nt  = W'($urandom);
        if (st_mode == 0) begin
            c.st = 1'b0;
        end else if (st_mode == 1) begin
            c.st = 1'b1;
            c.nt = W'(nt);
        end else begin
            c.st = ($urandom_range(0, 99) < st_pct);
        end
        c.exp = e;
        trace.push_back(c);
    endtask

    task automatic idle_cyc(input int st_mode, input int nt);
        add_cyc(ev(0, 0, 0, 0, 0, 0, 0, model_err, model_idx),
                -1, 1'b0, st_mode, nt);
    endtask

    // kind 0=weight 1=data 2=adder 3=write; lasts lat+1 cycles
    task automatic phase(input int kind, input int lat, input int idx,
                         input logic last, input logic hold);
        for (int c = 0; c <= lat; c++) begin
            if (kind == 1 && c == 1 && mark_ldw < 0) begin
                mark_ldw = trace.size();
            end
            add_cyc(ev(1, 0, kind == 0 && c == 0, kind == 1 && c == 0,
                       kind == 2, kind == 3 && c == 0, last, 0, idx),
                    kind, !hold && (c == lat), 2, 0);
        end
    endtask

    task automatic build_job(input int n, input int lmin, input int lmax,
                             input int to_tile);
        logic la;
        idle_cyc(1, n);
        model_err = 1'b0;
        if (n == 0) begin
            add_cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0, 2, 0);
            model_idx = 0;
            return;
        end
        phase(0, $urandom_range(lmin, lmax), 0, n == 1, 1'b0);
        for (int i = 0; i < n; i++) begin
            la = (i == n - 1);
            phase(1, $urandom_range(lmin, lmax), i, la, 1'b0);
            if (i == 1) begin
                mark_add1 = trace.size();
            end
            phase(2, $urandom_range(lmin, lmax), i, la, 1'b0);
            if (i == to_tile) begin
                phase(3, TO, i, la, 1'b1);
                model_err = 1'b1;
                model_idx = i;
                return;
            end
            phase(3, $urandom_range(lmin, lmax), i, la, 1'b0);
            add_cyc(ev(1, 0, 0, 0, 0, 0, la, 0, i), -1, 1'b0, 2, 0);
        end
        add_cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0), -1, 1'b0, 2, 0);
        model_idx = 0;
    endtask

    task automatic drive_zero();
        bus.start               = 1'b0;
        bus.num_tiles           = '0;
        bus.load_weight_done    = 1'b0;
        bus.load_data_exec_done = 1'b0;
        bus.adder_done          = 1'b0;
        bus.write_output_done   = 1'b0;
    endtask

    task automatic run_trace(input int abort_at);
        o_lw = 0; o_ld = 0; o_add = 0; o_wr = 0;
        o_done = 0; o_busy = 0; o_err = 0;
        o_done_at = -1; o_last_min = 9999; o_last_max = -1;
        for (int k = 0; k < trace.size(); k++) begin
            bus.start               = trace[k].st;
            bus.num_tiles           = trace[k].nt;
            bus.load_weight_done    = trace[k].lwd;
            bus.load_data_exec_done = trace[k].ldd;
            bus.adder_done          = trace[k].add;
            bus.write_output_done   = trace[k].wrd;
            cmp("cycle", k, act(), trace[k].exp);
            if (bus.load_weight_en) o_lw++;
            if (bus.load_data_exec_en) o_ld++;
            if (bus.adder_en) o_add++;
            if (bus.write_output_en) o_wr++;
            if (bus.busy) o_busy++;
            if (bus.err_timeout) o_err++;
            if (bus.done) begin
                o_done++;
                if (o_done_at < 0) o_done_at = k;
            end
            if (bus.is_last) begin
                if (int'(bus.tile_idx) < o_last_min) o_last_min = bus.tile_idx;
                if (int'(bus.tile_idx) > o_last_max) o_last_max = bus.tile_idx;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                cmp("async_reset", k, act(), '0);
                drive_zero();
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_err = 1'b0;
                model_idx = 0;
                break;
            end
            @(posedge clk);
            #1;
        end
        trace.delete();
        drive_zero();
    endtask

    initial begin
        drive_zero();
        rst = 1'b1;
        #1;
        cmp("reset_state", 0, act(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        build_job(3, 2, 2, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t1_lw_pulses", o_lw, 1);
        pin("t1_ld_pulses", o_ld, 3);
        pin("t1_wr_pulses", o_wr, 3);
        pin("t1_done_pulses", o_done, 1);
        pin("t1_last_idx_min", o_last_min, 2);
        pin("t1_last_idx_max", o_last_max, 2);

        build_job(2, 0, 0, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t2_latency", o_done_at, 10);
        pin("t2_adder_cycles", o_add, 2);

        build_job(0, 0, 0, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t3_latency", o_done_at, 1);
        pin("t3_requests", o_lw + o_ld + o_add + o_wr, 0);
        pin("t3_busy_cycles", o_busy, 0);

        stray_pct = 60;
        st_pct    = 50;
        mark_ldw  = -1;
        build_job(2, 1, 3, -1);
        trace[mark_ldw].st  = 1'b1;
        trace[mark_ldw].nt  = W'(5);
        trace[mark_ldw].add = 1'b1;
        trace[mark_ldw].ldd = 1'b0;
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t4_ld_pulses", o_ld, 2);
        pin("t4_done_pulses", o_done, 1);
        stray_pct = 25;
        st_pct    = 10;

        mark_add1 = -1;
        build_job(2, 1, 1, -1);
        run_trace(mark_add1);
        build_job(1, 0, 2, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t5_done_after_reset", o_done, 1);

`ifdef SEQ_TIMEOUT_EN
        build_job(1, 1, 1, 0);
        idle_cyc(0, 0);
        idle_cyc(0, 0);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t6_err_cycles", o_err, 3);
        pin("t6_no_done", o_done, 0);
        build_job(1, 0, 0, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("t6_err_cleared", o_err, 1);
        pin("t6_done_after_err", o_done, 1);
`endif

        build_job(255, 0, 0, -1);
        idle_cyc(0, 0);
        run_trace(-1);
        pin("max_tiles_latency", o_done_at, 1022);
        pin("max_tiles_ld", o_ld, 255);

        for (int j = 0; j < 25; j++) begin
            build_job($urandom_range(1, 6), 0, $urandom_range(0, 4), -1);
            for (int g = 0; g < $urandom_range(0, 3); g++) begin
                idle_cyc(0, 0);
            end
            run_trace(-1);
            pin("rand_done", o_done, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
